sram_like_responder: RTL

- Target (responder) end of the SRAM-like request/response bus the CPU core drives on its instruction and data ports (req/wr/size/wstrb/addr/wdata out, addr_ok/data_ok/rdata in).
- Accepts requests into an in-order outstanding queue and services them against a local word-addressed memory.
- Returns one data_ok per accepted request after a programmable latency.
- Used as a simulation/FPGA memory model behind the instruction and data ports, and as a bench target for the CPU's handshake logic.

---
 rtl/sram_like_responder_pkg.sv | 26 ++
 rtl/sram_like_responder_resp_fifo.sv | 56 +++++
 rtl/sram_like_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared constants for the SRAM-like responder: queue entry layout and LFSR setup.
// Entry layout, LSB first: size, wdata, word index, wstrb, wr.
package sram_like_responder_pkg;

   localparam int WR_W     = 1;
   localparam int STRB_W   = 4;
   localparam int DATA_W   = 32;
   localparam int SIZE_W   = 3;

   localparam int SIZE_LSB = 0;
   localparam int DATA_LSB = SIZE_LSB + SIZE_W;
   localparam int IDX_LSB  = DATA_LSB + DATA_W;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic int entry_w(input int addr_bits);
      return WR_W + STRB_W + addr_bits + DATA_W + SIZE_W;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// Circular DEPTH x W queue holding outstanding requests; head visible combinationally.
// Latency: an entry pushed on an edge is at the head the next cycle if the queue was empty.
// Backpressure: push is dropped when full and pop when empty; the owner gates with full/empty.
module sram_like_responder_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  slots [0:DEPTH-1];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign head_dat = slots[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         slots[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus target: in-order request queue serviced against a local word memory.
// Latency: data_ok LAT cycles after acceptance into an empty queue, then every LAT cycles.
// Backpressure: addr_ok low while full; SRAM_RESP_RAND_STALL_EN adds LFSR accept/latency stalls.
module sram_like_responder
   import sram_like_responder_pkg::*;
#(
   parameter int ADDR_BITS = 12,
   parameter int DEPTH     = 4,
   parameter int LAT       = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [2:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic [31:0] rdata,
   output logic        data_ok
);
   localparam int EW       = entry_w(ADDR_BITS);
   localparam int STRB_LSB = IDX_LSB + ADDR_BITS;
   localparam int WR_LSB   = STRB_LSB + STRB_W;
   localparam int CW       = $clog2(DEPTH) + 1;
   localparam int LW       = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [LW-1:0] LAST_CNT = LW'(LAT - 1);

   logic [EW-1:0]        push_dat;
   logic [EW-1:0]        head_dat;
   logic                 full;
   logic                 empty;
   logic [CW-1:0]        count;
   logic                 accept;
   logic                 retire;
   logic                 hold;
   logic [LW-1:0]        cnt;
   logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
   logic                 head_wr;
   logic [3:0]           head_strb;
   logic [ADDR_BITS-1:0] head_idx;
   logic [31:0]          head_wdata;
   logic                 unused_bits;

`ifdef SRAM_RESP_RAND_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= LFSR_SEED;
      else
         lfsr <= lfsr_next(lfsr);
   end

   assign addr_ok = !reset && !full && !lfsr[0];
   assign hold    = lfsr[1];
`else
   assign addr_ok = !reset && !full;
   assign hold    = 1'b0;
`endif

   assign accept   = req && addr_ok;
   assign push_dat = {wr, wstrb, addr[ADDR_BITS+1:2], wdata, size};

   sram_like_responder_resp_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_dat (push_dat),
      .pop      (retire),
      .head_dat (head_dat),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   assign head_wr    = head_dat[WR_LSB];
   assign head_strb  = head_dat[STRB_LSB +: STRB_W];
   assign head_idx   = head_dat[IDX_LSB +: ADDR_BITS];
   assign head_wdata = head_dat[DATA_LSB +: DATA_W];

   // Reset gating keeps queued work from completing in the cycle it is being dropped
   assign data_ok = !reset && !empty && !hold && (cnt == LAST_CNT);
   assign retire  = data_ok;
   assign rdata   = (data_ok && !head_wr) ? mem[head_idx] : 32'd0;

   always_ff @(posedge clk) begin
      if (reset || retire)
         cnt <= '0;
      else if (!empty && !hold)
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (retire && head_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (head_strb[i])
               mem[head_idx][8*i +: 8] <= head_wdata[8*i +: 8];
         end
      end
   end

   // Size is carried for observability only; low and aliased address bits are ignored
   assign unused_bits = ^{count, head_dat[SIZE_LSB +: SIZE_W], addr[31:ADDR_BITS+2], addr[1:0]};

endmodule
